// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect scheduler: request ids, voice count and
// the dispatcher state encoding.
package sfx_pkg;

    localparam int unsigned NUM_VOICES = 3;

    localparam logic [1:0] SFX_JUMP  = 2'd0;
    localparam logic [1:0] SFX_SCORE = 2'd1;
    localparam logic [1:0] SFX_DEATH = 2'd2;
    localparam logic [1:0] SFX_FLUSH = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRIG     = 2'd1,
        WAIT_ACK = 2'd2
    } sched_state_e;

    // One-hot trigger vector for a voice id; flush (3) has no voice.
    function automatic logic [NUM_VOICES-1:0] voice_onehot(input logic [1:0] id);
        case (id)
            SFX_JUMP:  return 3'b001;
            SFX_SCORE: return 3'b010;
            SFX_DEATH: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sfx_req_fifo.sv
// Request queue for jump/score ids: synchronous FIFO with clear, level, and
// head/tail visibility (tail feeds request coalescing).
module sfx_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         tail,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    tail_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign push_ok  = push && !full && !clear;
    assign pop_ok   = pop && !empty && !clear;
    assign tail_ptr = wr_ptr_q - PW'(1);
    assign head     = mem_q[rd_ptr_q];
    assign tail     = mem_q[tail_ptr];
    assign level    = level_q;

    // NOTE: every always_comb output gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; level gates every read, so stale entries are never observed.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Routes sound requests to the jump/score/death voices with a queued FIFO and a
// death priority slot. Define SFX_COALESCE_EN to absorb repeats of the tail entry.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TRIG_CYCLES = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [1:0]                  req_id,
    output logic                        req_ready,
    input  logic [NUM_VOICES-1:0]       voice_busy,
    output logic [NUM_VOICES-1:0]       trig,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic [7:0]                  dropped,
    output logic                        ack_timeout
);

    localparam int CW = 10;

`ifdef SFX_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    sched_state_e          state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            voice_q, voice_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic                  prio_q, prio_d;
    logic [7:0]            dropped_q, dropped_d;
    logic                  ack_timeout_q, ack_timeout_d;

    logic                  fifo_req, flush_req, death_req;
    logic                  absorb, drop, pop, prio_take;
    logic [1:0]            fifo_head, fifo_tail;
    logic                  fifo_full, fifo_empty;

    assign fifo_req  = req_valid && (req_id == SFX_JUMP || req_id == SFX_SCORE);
    assign death_req = req_valid && (req_id == SFX_DEATH);
    assign flush_req = req_valid && (req_id == SFX_FLUSH);
    assign absorb    = COALESCE_EN && fifo_req && !fifo_empty && (fifo_tail == req_id);
    // req_ready comes from the registered level, so a same-cycle pop never frees a slot.
    assign drop      = fifo_req && !absorb && fifo_full;

    sfx_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_req && !absorb),
        .pop   (pop),
        .clear (flush_req),
        .din   (req_id),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        voice_d       = voice_q;
        trig_d        = trig_q;
        ack_timeout_d = ack_timeout_q;
        pop           = 1'b0;
        prio_take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (prio_q) begin
                    prio_take = 1'b1;
                    voice_d   = SFX_DEATH;
                    trig_d    = voice_onehot(SFX_DEATH);
                    cnt_d     = '0;
                    state_d   = TRIG;
                end else if (!fifo_empty && !voice_busy[fifo_head]) begin
                    pop     = 1'b1;
                    voice_d = fifo_head;
                    trig_d  = voice_onehot(fifo_head);
                    cnt_d   = '0;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                    trig_d  = '0;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_ACK: begin
                if (voice_busy[voice_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    ack_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                trig_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A fresh death request wins over the slot being consumed in the same cycle.
    always_comb begin
        prio_d = prio_q;
        if (flush_req)      prio_d = 1'b0;
        else if (death_req) prio_d = 1'b1;
        else if (prio_take) prio_d = 1'b0;
    end

    always_comb begin
        dropped_d = dropped_q;
        if (drop && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            voice_q       <= '0;
            trig_q        <= '0;
            prio_q        <= 1'b0;
            dropped_q     <= '0;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            voice_q       <= voice_d;
            trig_q        <= trig_d;
            prio_q        <= prio_d;
            dropped_q     <= dropped_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    assign req_ready   = !fifo_full;
    assign trig        = trig_q;
    assign dropped     = dropped_q;
    assign ack_timeout = ack_timeout_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler at default parameters; expectations are
// hand-computed edge by edge. Coalescing expectations follow SFX_COALESCE_EN.
module tb_sfx_scheduler;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_id;
    logic       req_ready;
    logic [2:0] voice_busy;
    logic [2:0] trig;
    logic [2:0] level;
    logic [7:0] dropped;
    logic       ack_timeout;

    int checks = 0;
    int errors = 0;

    sfx_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_ready   (req_ready),
        .voice_busy  (voice_busy),
        .trig        (trig),
        .level       (level),
        .dropped     (dropped),
        .ack_timeout (ack_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-cycle request strobe; returns just after the accepting edge.
    task automatic req(input logic [1:0] id);
        req_valid = 1'b1;
        req_id    = id;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_id     = 2'd0;
        voice_busy = 3'b000;
        tick(3);
        check("rst_trig",    32'(trig),        32'h0);
        check("rst_level",   32'(level),       32'h0);
        check("rst_dropped", 32'(dropped),     32'h0);
        check("rst_ackto",   32'(ack_timeout), 32'h0);
        check("rst_ready",   32'(req_ready),   32'h1);
        reset = 1'b0;
        tick();

        // Single jump: accepted at N, trig[0] high N+1..N+8, low at N+9.
        req(2'd0);
        check("j_acc_level", 32'(level), 32'h1);
        check("j_acc_trig",  32'(trig),  32'h0);
        tick();
        check("j_rise_trig",  32'(trig),  32'h1);
        check("j_rise_level", 32'(level), 32'h0);
        tick(7);
        check("j_last_trig", 32'(trig), 32'h1);
        tick();
        check("j_fall_trig", 32'(trig), 32'h0);
        tick();
        voice_busy = 3'b001;
        tick();
        voice_busy = 3'b000;
        tick(70);
        check("j_acked_no_to", 32'(ack_timeout), 32'h0);

        // Six scores with voice 1 busy: four queue, two drop.
        voice_busy = 3'b010;
        req_valid  = 1'b1;
        req_id     = 2'd1;
        tick(6);
        req_valid  = 1'b0;
        check("full_level",   32'(level),     32'h4);
        check("full_ready",   32'(req_ready), 32'h0);
        check("full_dropped", 32'(dropped),   32'h2);
        check("full_trig",    32'(trig),      32'h0);

        // Push into a full FIFO on the pop edge is still rejected.
        voice_busy = 3'b000;
        req(2'd1);
        check("poppush_level",   32'(level),     32'h3);
        check("poppush_dropped", 32'(dropped),   32'h3);
        check("poppush_trig",    32'(trig),      32'h2);
        check("poppush_ready",   32'(req_ready), 32'h1);

        // Flush mid-pulse: queue empties, current pulse completes, nothing follows.
        req(2'd3);
        check("flush_level", 32'(level), 32'h0);
        check("flush_trig",  32'(trig),  32'h2);
        tick(6);
        check("flush_pulse_last", 32'(trig), 32'h2);
        tick();
        check("flush_pulse_fall", 32'(trig), 32'h0);
        voice_busy = 3'b010;
        tick();
        voice_busy = 3'b000;
        tick(20);
        check("flush_quiet_trig",  32'(trig),  32'h0);
        check("flush_quiet_level", 32'(level), 32'h0);

        // Jump + score queued, death arrives during jump pulse: order jump, death, score.
        req(2'd0);
        check("pr_q1_level", 32'(level), 32'h1);
        req(2'd1);
        check("pr_popush_level", 32'(level), 32'h1);
        check("pr_jump_trig",    32'(trig),  32'h1);
        req(2'd2);
        tick(6);
        check("pr_jump_last", 32'(trig), 32'h1);
        tick();
        check("pr_jump_fall", 32'(trig), 32'h0);
        voice_busy = 3'b001;
        tick();
        check("pr_ack_trig", 32'(trig), 32'h0);
        tick();
        check("pr_death_trig",  32'(trig),  32'h4);
        check("pr_death_level", 32'(level), 32'h1);
        voice_busy = 3'b000;
        tick(7);
        check("pr_death_last", 32'(trig), 32'h4);
        tick();
        check("pr_death_fall", 32'(trig), 32'h0);
        voice_busy = 3'b100;
        tick(2);
        check("pr_score_trig",  32'(trig),  32'h2);
        check("pr_score_level", 32'(level), 32'h0);

        // Score never acknowledged: timeout 64 edges after fall, then queued jump dispatches.
        voice_busy = 3'b000;
        req(2'd0);
        check("to_q_level", 32'(level), 32'h1);
        tick(6);
        check("to_pulse_last", 32'(trig), 32'h2);
        tick();
        check("to_pulse_fall", 32'(trig),        32'h0);
        check("to_fall_flag",  32'(ack_timeout), 32'h0);
        tick(63);
        check("to_before_flag", 32'(ack_timeout), 32'h0);
        tick();
        check("to_flag",      32'(ack_timeout), 32'h1);
        check("to_idle_trig", 32'(trig),        32'h0);
        tick();
        check("to_next_trig",  32'(trig),  32'h1);
        check("to_next_level", 32'(level), 32'h0);
        tick(8);
        voice_busy = 3'b001;
        tick();

        // Four jumps while voice 0 stays busy.
        req_valid = 1'b1;
        req_id    = 2'd0;
        tick(4);
        req_valid = 1'b0;
`ifdef SFX_COALESCE_EN
        check("coal_level", 32'(level), 32'h1);
`else
        check("coal_level", 32'(level), 32'h4);
`endif
        check("coal_dropped", 32'(dropped), 32'h3);
        check("coal_trig",    32'(trig),    32'h0);
        req(2'd3);
        check("coal_flush_level", 32'(level), 32'h0);

        // Death ignores voice_busy; then reset mid-pulse.
        voice_busy = 3'b111;
        req(2'd2);
        tick();
        check("death_busy_trig", 32'(trig), 32'h4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_trig",    32'(trig),        32'h0);
        check("midrst_dropped", 32'(dropped),     32'h0);
        check("midrst_ackto",   32'(ack_timeout), 32'h1 ^ 32'h1);
        tick(12);
        check("midrst_quiet", 32'(trig), 32'h0);

        // Dropped counter saturates at 255.
        voice_busy = 3'b010;
        req_valid  = 1'b1;
        req_id     = 2'd1;
        tick(264);
        req_valid  = 1'b0;
        check("sat_dropped", 32'(dropped), 32'hFF);
        check("sat_level",   32'(level),   32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sequences sound-effect requests from the processor's memory-mapped sound port into the three audio voices (jump, score, death). It queues requests, holds each trigger pulse long enough to be sampled by the slower audio-clock voice generators, waits for the voice to acknowledge by raising its enable, and gives death priority over everything queued. It sits between the processor's `w_sound`/`val_out` path and the `iTrig` inputs of the three voice generators.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request queue entries; power of two, 2..16.
- `TRIG_CYCLES`, 8: trigger pulse width in `clock` cycles; 1..255.
- `ACK_TIMEOUT`, 64: maximum cycles to wait for voice acknowledge; 1..1023.

Ports (reset reset, synchronous, active-high; clock clock):
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: sound request strobe.
- `req_id` in 2: 0 jump, 1 score, 2 death, 3 flush.
- `req_ready` out 1: queue can accept a jump or score request.
- `voice_busy` in 3: per-voice enable, already synchronized to `clock`; bit v = voice v.
- `trig` out 3: per-voice trigger pulse.
- `level` out clog2(FIFO_DEPTH)+1: queued entry count.
- `dropped` out 8: saturating count of rejected requests.
- `ack_timeout` out 1: sticky flag set when an acknowledge wait times out.

## Operation
- Request routing: id 0/1 goes into the FIFO when `req_ready`. Id 2 goes into a one-entry priority slot, which is always accepted; a second death request overwrites the pending one. Id 3 empties the FIFO and the priority slot, and is not queued.
- A request with `req_valid` high, id 0/1, and `req_ready` low is discarded and increments `dropped`. `dropped` saturates at 255.
- `req_ready` = FIFO not full. It does not depend on the priority slot.
- Dispatcher FSM:
  - IDLE → TRIG when the priority slot is full. The slot is served first; voice_busy is ignored for death.
  - IDLE → TRIG otherwise, when the FIFO is non-empty and `voice_busy[head]` is low. The entry is popped on this transition.
  - TRIG: `trig[v]` is high for exactly TRIG_CYCLES cycles, then the FSM goes to WAIT_ACK.
  - WAIT_ACK: returns to IDLE on `voice_busy[v]` high, or after ACK_TIMEOUT cycles. A timeout sets `ack_timeout`. The flag clears only on reset.
- Only one `trig` bit is ever high at a time.
- If the FIFO head's voice is busy, the dispatcher waits in IDLE. There is no head-of-line bypass, except that the priority slot preempts the wait.
- Flush during TRIG or WAIT_ACK: the current pulse and wait complete normally; only pending entries are cleared.
- Flush and an id 0/1 push in the same cycle cannot occur, because there is a single request port.
- Pop and push in the same cycle: `level` is unchanged. A push into a full FIFO in the same cycle as a pop is still rejected, because `req_ready` is registered from the pre-pop state.
- The FIFO pointers wrap modulo FIFO_DEPTH. `level` ranges 0..FIFO_DEPTH.

## Timing
- Reset values: `trig`=0, `level`=0, `dropped`=0, `ack_timeout`=0, `req_ready`=1. The FSM goes to IDLE, and the priority slot is emptied.
- Reset mid-pulse: `trig` is low after the reset edge, and pending requests are lost.
- Latency: a request accepted at edge N with the FSM in IDLE and the voice free gives `trig` high from edge N+1 through edge N+1+TRIG_CYCLES, where it falls.
- `level` and `req_ready` update at the edge that accepts or pops.
- The WAIT_ACK counter starts at the edge where `trig` falls. A timeout exits at edge +ACK_TIMEOUT.
- Minimum spacing between two triggers is TRIG_CYCLES+2 cycles: the FSM passes through WAIT_ACK and IDLE for at least one cycle each.

## Configuration
- `SFX_COALESCE_EN`: when defined, an id 0/1 request equal to the current FIFO tail entry, with `level`>0, is absorbed. It is not queued and does not count in `dropped`; `req_ready` is ignored for it.
- When not defined, every request is queued or dropped as above.

## Structure
- Package `sfx_pkg` holds:
  - ID constants `SFX_JUMP`=0, `SFX_SCORE`=1, `SFX_DEATH`=2, `SFX_FLUSH`=3.
  - The dispatcher state encoding: IDLE, TRIG, WAIT_ACK.
  - The voice count, 3.
- Sub-module `sfx_req_fifo` provides a synchronous FIFO (push, pop, clear, level, full, empty, tail value). The FSM, priority slot and counters stay in `sfx_scheduler`.

## Test plan
- Single jump, defaults, voices idle, request at edge 10 → `trig[0]` high on edges 11..18, low at 19. `voice_busy[0]` raised at 21 → IDLE at 22.
- Push 6 score requests back-to-back with `voice_busy[1]` held high, coalescing off → `level`=4, `req_ready`=0, `dropped`=2, no `trig`.
- Queue jump and score, then death while the jump pulse is active → death is dispatched after the jump acknowledge and before the score; `trig[2]` pulse is 8 cycles.
- Voice never acknowledges → `ack_timeout`=1 exactly 64 cycles after `trig` falls; the next queued entry then dispatches.
- Flush with 3 queued entries mid-pulse → the current pulse completes, `level`=0, and no further `trig`.
- With `SFX_COALESCE_EN` defined, 4 consecutive jump requests while the voice is busy → `level`=1, `dropped`=0.
